// File: rtl/ddiff_measure.sv
// Measures the arrival-time difference between event strobes ev_a and ev_b and
// presents it as an offset-binary sample through a one-entry valid/ready buffer.
module ddiff_measure #(
  parameter int DDIFF_BITS = 9,
  parameter int CNT_BITS   = 8,
  parameter int WINDOW     = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ev_a,
  input  logic                  ev_b,
  input  logic                  ddiff_ready,
  output logic [DDIFF_BITS-1:0] ddiff_b,
  output logic                  ddiff_valid,
  output logic                  timeout,
  output logic                  ovf
);

  typedef enum logic [1:0] {IDLE, WAIT_A, WAIT_B} state_t;

  localparam logic [CNT_BITS-1:0]   WIN  = CNT_BITS'(WINDOW);
  localparam logic [DDIFF_BITS-1:0] HALF = DDIFF_BITS'(1) << (DDIFF_BITS - 1);

  state_t                state, state_nxt;
  logic [CNT_BITS-1:0]   cnt, cnt_nxt, cnt_inc;
  logic                  res_valid;
  logic [DDIFF_BITS-1:0] res_val;

  // The count seen in a waiting cycle already includes that cycle.
  assign cnt_inc = (cnt >= WIN) ? WIN : cnt + CNT_BITS'(1);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    res_valid = 1'b0;
    res_val   = HALF;
    timeout   = 1'b0;
    case (state)
      IDLE: begin
        if (ev_a && ev_b) begin
          res_valid = 1'b1;
        end else if (ev_a) begin
          state_nxt = WAIT_B;
          cnt_nxt   = '0;
        end else if (ev_b) begin
          state_nxt = WAIT_A;
          cnt_nxt   = '0;
        end
      end
      WAIT_B: begin
        cnt_nxt = cnt_inc;
        if (ev_b) begin
          res_valid = 1'b1;
          res_val   = HALF + DDIFF_BITS'(cnt_inc);
          state_nxt = IDLE;
        end else if (ev_a) begin
          cnt_nxt = '0;
        end else if (cnt_inc == WIN) begin
          timeout   = 1'b1;
          state_nxt = IDLE;
        end
      end
      WAIT_A: begin
        cnt_nxt = cnt_inc;
        if (ev_a) begin
          res_valid = 1'b1;
          res_val   = HALF - DDIFF_BITS'(cnt_inc);
          state_nxt = IDLE;
        end else if (ev_b) begin
          cnt_nxt = '0;
        end else if (cnt_inc == WIN) begin
          timeout   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Results and timeouts formed during a reset cycle are discarded.
    if (reset) begin
      timeout   = 1'b0;
      res_valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // A result arriving while the buffer is held full is dropped and flagged.
  always_ff @(posedge clk) begin
    if (reset) begin
      ddiff_b     <= HALF;
      ddiff_valid <= 1'b0;
      ovf         <= 1'b0;
    end else if (res_valid && (!ddiff_valid || ddiff_ready)) begin
      ddiff_b     <= res_val;
      ddiff_valid <= 1'b1;
    end else if (res_valid) begin
      ovf <= 1'b1;
    end else if (ddiff_valid && ddiff_ready) begin
      ddiff_valid <= 1'b0;
    end
  end

endmodule
